// File: rtl/stream_demux_pkg.sv
// Shared sizing constants for the six-channel stream demultiplexer.
package stream_demux_pkg;
  localparam int NUM_CH     = 6;
  localparam int SEL_W      = 3;
  localparam int DROP_CNT_W = 8;
endpackage

// File: rtl/stream_demux_slot.sv
// One-entry holding register for a single demux output channel.
module stream_demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A new word wins over the drain so a transfer and an accept in the same
  // cycle keep the slot full and give one word per cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/stream_demux6.sv
// Routes one upstream stream to six per-channel slots; in_sel 6/7 drops words.
// Optional drop counter enabled with macro STREAM_DEMUX6_DROP_CNT_EN.
module stream_demux6
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [WIDTH-1:0]      in_data,
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic [WIDTH-1:0]      out_data0,
  output logic [WIDTH-1:0]      out_data1,
  output logic [WIDTH-1:0]      out_data2,
  output logic [WIDTH-1:0]      out_data3,
  output logic [WIDTH-1:0]      out_data4,
  output logic [WIDTH-1:0]      out_data5,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  logic [NUM_CH-1:0] slot_valid;
  logic [NUM_CH-1:0] load;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic              in_ready_c;
  logic              accept;

  // Ready depends only on slot state and out_ready, never on in_valid.
  always_comb begin
    in_ready_c = 1'b1;
    load       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_sel == SEL_W'(i)) in_ready_c = !slot_valid[i] || out_ready[i];
    end
    accept = in_valid && in_ready_c;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = accept && (in_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    stream_demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .valid     (slot_valid[g]),
      .data      (slot_data[g])
    );
  end

  assign in_ready  = in_ready_c;
  assign out_valid = slot_valid;
  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
  assign out_data4 = slot_data[4];
  assign out_data5 = slot_data[5];

`ifdef STREAM_DEMUX6_DROP_CNT_EN
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    drop       = accept && (in_sel >= SEL_W'(NUM_CH));
    drop_cnt_d = drop_cnt_q;
    if (drop) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_stream_demux6.sv
// Self-checking bench for stream_demux6: directed scenarios plus random traffic
// compared every cycle against a per-channel behavioural model.
module tb_stream_demux6;
  localparam int W = 4;
`ifdef STREAM_DEMUX6_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_sel;
  logic [W-1:0] in_data;
  logic [5:0]   out_valid;
  logic [5:0]   out_ready;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3, out_data4, out_data5;
  logic [7:0]   drop_cnt;
  logic [W-1:0] od [6];

  int checks = 0;
  int errors = 0;

  stream_demux6 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
    .out_data3(out_data3), .out_data4(out_data4), .out_data5(out_data5),
    .drop_cnt(drop_cnt)
  );

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign od[4] = out_data4;
  assign od[5] = out_data5;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel holds at most one word; drops are counted.
  bit           m_full [6];
  logic [W-1:0] m_data [6];
  int           m_drops = 0;
  bit           armed = 1'b0;

  always @(negedge clk) begin
    bit exp_rdy;
    bit acc;
    exp_rdy = (in_sel >= 3'd6) ? 1'b1 : (!m_full[in_sel] || out_ready[in_sel]);
    if (armed) begin
      logic [5:0] mv;
      for (int i = 0; i < 6; i++) mv[i] = m_full[i];
      check("model_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      check("model_out_valid", {26'd0, out_valid}, {26'd0, mv});
      for (int i = 0; i < 6; i++)
        check($sformatf("model_out_data%0d", i), {28'd0, od[i]}, {28'd0, m_data[i]});
      check("model_drop_cnt", {24'd0, drop_cnt}, CNT_EN ? m_drops : 0);
    end
    acc = in_valid && exp_rdy;
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = '0;
      end
      m_drops = 0;
      armed = 1'b1;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (acc && in_sel == i) begin
          m_full[i] = 1'b1;
          m_data[i] = in_data;
        end else if (m_full[i] && out_ready[i]) begin
          m_full[i] = 1'b0;
        end
      end
      if (acc && in_sel >= 3'd6 && m_drops < 255) m_drops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; out_ready = 6'h00;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {26'd0, out_valid}, 32'h0);
    check("reset_drop_cnt", {24'd0, drop_cnt}, 32'h0);
    check("reset_out_data3", {28'd0, out_data3}, 32'h0);

    // Basic routing to channel 3
    step();
    out_ready = 6'h3F;
    send(3'd3, 4'hA);
    @(negedge clk); check("route_in_ready", {31'd0, in_ready}, 32'd1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("route_out_valid", {26'd0, out_valid}, 32'b001000);
    check("route_out_data3", {28'd0, out_data3}, 32'hA);
    step();
    @(negedge clk); check("route_cleared", {26'd0, out_valid}, 32'h0);

    // Backpressure on channel 2
    out_ready = 6'h3B;
    send(3'd2, 4'h5);
    step();
    send(3'd2, 4'h6);
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_hold_5a", {28'd0, out_data2}, 32'h5);
    step();
    @(negedge clk);
    check("bp_hold_5b", {28'd0, out_data2}, 32'h5);
    check("bp_valid2", {31'd0, out_valid[2]}, 32'd1);
    out_ready = 6'h3F;
    #1 check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_6", {28'd0, out_data2}, 32'h6);
    check("bp_valid2_again", {31'd0, out_valid[2]}, 32'd1);
    step();
    @(negedge clk); check("bp_drained", {26'd0, out_valid}, 32'h0);

    // Streaming 8 words to channel 0
    for (int k = 0; k < 8; k++) begin
      send(3'd0, W'(k + 3));
      @(negedge clk);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (k > 0) check("stream_data", {28'd0, out_data0}, k + 2);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk); check("stream_last", {28'd0, out_data0}, 32'hA);
    step();

    // Channel independence: 1 stalled, 4 flows
    out_ready = 6'h3D;
    send(3'd1, 4'h7);
    step();
    send(3'd4, 4'hC);
    @(negedge clk); check("indep_in_ready", {31'd0, in_ready}, 32'd1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("indep_valid4", {31'd0, out_valid[4]}, 32'd1);
    check("indep_data4", {28'd0, out_data4}, 32'hC);
    check("indep_data1", {28'd0, out_data1}, 32'h7);
    step();
    @(negedge clk);
    check("indep_valid", {26'd0, out_valid}, 32'b000010);
    check("indep_data1_kept", {28'd0, out_data1}, 32'h7);
    out_ready = 6'h3F;
    step();

    // Drops: 300 words to channel 7
    for (int k = 0; k < 300; k++) begin
      send(3'd7, W'($urandom));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drop_cnt_sat", {24'd0, drop_cnt}, CNT_EN ? 32'd255 : 32'd0);
    check("drop_no_valid", {26'd0, out_valid}, 32'h0);

    // Reset mid-operation with channels 0 and 5 loaded
    out_ready = 6'h00;
    send(3'd0, 4'h1);
    step();
    send(3'd5, 4'h2);
    step();
    in_valid = 1'b0;
    @(negedge clk); check("mid_loaded", {26'd0, out_valid}, 32'b100001);
    reset = 1'b1;
    send(3'd7, 4'h3);
    step();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("mid_reset_valid", {26'd0, out_valid}, 32'h0);
    check("mid_reset_drop", {24'd0, drop_cnt}, 32'h0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = W'($urandom);
      out_ready = 6'($urandom);
      step();
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
